clock_mode_ctrl: RTL and testbench

- Consumer of the one-cycle debounced pushbutton pulses (MODE, UP) produced by the front-panel input conditioners.
- Holds the time-of-day registers (hour/minute/second) and a three-state mode FSM: run, set hour, set minute.
- Generates a blink enable for the digit being adjusted.
- Sits between the button conditioners and the seven-segment display driver; all timing comes from the shared 1 Hz and 1 kHz enable ticks.

---
 rtl/clock_mode_ctrl.sv | 137 +++++++++++++
 tb/tb_clock_mode_ctrl.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/clock_mode_ctrl.sv
// Time-of-day keeper with a run / set-hour / set-minute mode FSM.
// It also produces a blink enable for the field that is being adjusted.
module clock_mode_ctrl #(
    parameter int BLINK_HALF = 500,
    parameter int HOUR_MOD   = 24
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       ENABLE_Hz,
    input  logic       ENABLE_kHz,
    input  logic       MODE,
    input  logic       UP,
    output logic [4:0] HOUR,
    output logic [5:0] MIN,
    output logic [5:0] SEC,
    output logic [1:0] STATE,
    output logic       BLINK
);

    typedef enum logic [1:0] {
        RUN      = 2'b00,
        SET_HOUR = 2'b01,
        SET_MIN  = 2'b10,
        ILLEGAL  = 2'b11
    } state_t;

    localparam int CNT_W = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BLINK_HALF - 1);

    logic [1:0]       state_q, state_d;
    logic [4:0]       hour_q, hour_d;
    logic [5:0]       min_q, min_d;
    logic [5:0]       sec_q, sec_d;
    logic             blink_q, blink_d;
    logic [CNT_W-1:0] bcnt_q, bcnt_d;

    function automatic logic [5:0] inc60(input logic [5:0] v);
        return (v == 6'd59) ? 6'd0 : v + 6'd1;
    endfunction

    function automatic logic [4:0] inc_hour(input logic [4:0] v);
        return (v == 5'(HOUR_MOD - 1)) ? 5'd0 : v + 5'd1;
    endfunction

    always_comb begin
        state_d = state_q;
        hour_d  = hour_q;
        min_d   = min_q;
        sec_d   = sec_q;
        blink_d = blink_q;
        bcnt_d  = bcnt_q;

        // Free-running blink advance; the state cases below override it.
        if (ENABLE_kHz) begin
            if (bcnt_q == CNT_MAX) begin
                bcnt_d  = '0;
                blink_d = ~blink_q;
            end else begin
                bcnt_d = bcnt_q + CNT_W'(1);
            end
        end

        case (state_q)
            RUN: begin
                blink_d = 1'b0;
                bcnt_d  = '0;
                if (ENABLE_Hz) begin
                    sec_d = inc60(sec_q);
                    if (sec_q == 6'd59) begin
                        min_d = inc60(min_q);
                        if (min_q == 6'd59) begin
                            hour_d = inc_hour(hour_q);
                        end
                    end
                end
                if (MODE) begin
                    state_d = SET_HOUR;
                    blink_d = 1'b1;
                end
            end
            SET_HOUR: begin
                if (MODE) begin
                    state_d = SET_MIN;
                    blink_d = 1'b1;
                    bcnt_d  = '0;
                end else if (UP) begin
                    hour_d  = inc_hour(hour_q);
                    blink_d = 1'b1;
                    bcnt_d  = '0;
                end
            end
            SET_MIN: begin
                if (MODE) begin
                    state_d = RUN;
                    sec_d   = 6'd0;
                    blink_d = 1'b0;
                    bcnt_d  = '0;
                end else if (UP) begin
                    min_d   = inc60(min_q);
                    blink_d = 1'b1;
                    bcnt_d  = '0;
                end
            end
            default: begin
                // Unreachable encoding: recover to RUN, leave time alone.
                state_d = RUN;
                blink_d = 1'b0;
                bcnt_d  = '0;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= RUN;
            hour_q  <= 5'd0;
            min_q   <= 6'd0;
            sec_q   <= 6'd0;
            blink_q <= 1'b0;
            bcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            hour_q  <= hour_d;
            min_q   <= min_d;
            sec_q   <= sec_d;
            blink_q <= blink_d;
            bcnt_q  <= bcnt_d;
        end
    end

    assign HOUR  = hour_q;
    assign MIN   = min_q;
    assign SEC   = sec_q;
    assign STATE = state_q;
    assign BLINK = blink_q;

endmodule

// File: tb/tb_clock_mode_ctrl.sv
// Directed bench for clock_mode_ctrl: a vector table plus hand-written
// sequences for reset, rollover, long UP runs and illegal-state recovery.
module tb_clock_mode_ctrl;

    logic       CLK, RST, ENABLE_Hz, ENABLE_kHz, MODE, UP;
    logic [4:0] HOUR;
    logic [5:0] MIN, SEC;
    logic [1:0] STATE;
    logic       BLINK;

    int n_checks = 0;
    int n_fail   = 0;

    clock_mode_ctrl #(.BLINK_HALF(4), .HOUR_MOD(24)) dut (
        .CLK(CLK), .RST(RST), .ENABLE_Hz(ENABLE_Hz), .ENABLE_kHz(ENABLE_kHz),
        .MODE(MODE), .UP(UP), .HOUR(HOUR), .MIN(MIN), .SEC(SEC),
        .STATE(STATE), .BLINK(BLINK)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic       m, u, h, k;
        logic [1:0] st;
        logic [4:0] hr;
        logic [5:0] mn, sc;
        logic       b;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic m, u, h, k, input logic [1:0] st,
                       input int hr, mn, sc, input logic b);
        vec_t v;
        v.m = m; v.u = u; v.h = h; v.k = k; v.st = st;
        v.hr = 5'(hr); v.mn = 6'(mn); v.sc = 6'(sc); v.b = b;
        vecs.push_back(v);
    endtask

    task automatic chk(input string nm, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, got, exp);
        end
    endtask

    task automatic chk_all(input string nm, input int st, hr, mn, sc, b);
        chk({nm, ".STATE"}, int'(STATE), st);
        chk({nm, ".HOUR"},  int'(HOUR),  hr);
        chk({nm, ".MIN"},   int'(MIN),   mn);
        chk({nm, ".SEC"},   int'(SEC),   sc);
        chk({nm, ".BLINK"}, int'(BLINK), b);
    endtask

    task automatic pulse(input logic m, u, h, k);
        MODE = m; UP = u; ENABLE_Hz = h; ENABLE_kHz = k;
        @(posedge CLK);
        #1;
        MODE = 1'b0; UP = 1'b0; ENABLE_Hz = 1'b0; ENABLE_kHz = 1'b0;
    endtask

    task automatic do_reset();
        RST = 1'b1;
        repeat (2) @(posedge CLK);
        #1 RST = 1'b0;
    endtask

    initial begin
        RST = 1'b1; MODE = 1'b0; UP = 1'b0; ENABLE_Hz = 1'b0; ENABLE_kHz = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        chk_all("reset_hold", 0, 0, 0, 0, 0);
        RST = 1'b0;

        //  m  u  h  k   st     hr mn sc b
        add(0, 0, 1, 0, 2'b00, 0, 0, 1, 0);   // tick in RUN
        add(0, 1, 0, 0, 2'b00, 0, 0, 1, 0);   // UP ignored in RUN
        add(1, 0, 1, 0, 2'b01, 0, 0, 2, 1);   // MODE+tick: tick applied
        add(0, 0, 1, 0, 2'b01, 0, 0, 2, 1);   // SEC frozen in SET_HOUR
        add(0, 1, 0, 0, 2'b01, 1, 0, 2, 1);
        add(1, 1, 0, 0, 2'b10, 1, 0, 2, 1);   // MODE wins over UP
        add(0, 1, 0, 0, 2'b10, 1, 1, 2, 1);
        add(0, 0, 1, 0, 2'b10, 1, 1, 2, 1);   // SEC frozen in SET_MIN
        add(0, 1, 0, 0, 2'b10, 1, 2, 2, 1);
        add(1, 0, 1, 0, 2'b00, 1, 2, 0, 0);   // exit clears SEC, tick dropped
        add(0, 0, 1, 0, 2'b00, 1, 2, 1, 0);
        add(0, 0, 0, 1, 2'b00, 1, 2, 1, 0);   // kHz in RUN: no blink
        add(1, 0, 0, 0, 2'b01, 1, 2, 1, 1);
        add(0, 0, 0, 1, 2'b01, 1, 2, 1, 1);
        add(0, 0, 0, 1, 2'b01, 1, 2, 1, 1);
        add(0, 0, 0, 1, 2'b01, 1, 2, 1, 1);
        add(0, 0, 0, 1, 2'b01, 1, 2, 1, 0);   // half-period reached
        add(0, 0, 0, 1, 2'b01, 1, 2, 1, 0);
        add(0, 1, 0, 0, 2'b01, 2, 2, 1, 1);   // UP in blank phase
        add(0, 0, 0, 1, 2'b01, 2, 2, 1, 1);
        add(0, 0, 0, 1, 2'b01, 2, 2, 1, 1);
        add(0, 0, 0, 1, 2'b01, 2, 2, 1, 1);
        add(0, 1, 0, 1, 2'b01, 3, 2, 1, 1);   // UP on the toggle cycle
        add(0, 0, 0, 1, 2'b01, 3, 2, 1, 1);
        add(0, 0, 0, 1, 2'b01, 3, 2, 1, 1);
        add(0, 0, 0, 1, 2'b01, 3, 2, 1, 1);
        add(0, 0, 0, 1, 2'b01, 3, 2, 1, 0);
        add(0, 0, 0, 1, 2'b01, 3, 2, 1, 0);
        add(0, 0, 0, 1, 2'b01, 3, 2, 1, 0);
        add(0, 0, 0, 1, 2'b01, 3, 2, 1, 0);
        add(0, 0, 0, 1, 2'b01, 3, 2, 1, 1);   // back to visible
        add(1, 0, 0, 1, 2'b10, 3, 2, 1, 1);   // entering SET_MIN restarts blink
        add(1, 0, 0, 0, 2'b00, 3, 2, 0, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            pulse(vecs[i].m, vecs[i].u, vecs[i].h, vecs[i].k);
            chk_all($sformatf("vec%0d", i), int'(vecs[i].st), int'(vecs[i].hr),
                    int'(vecs[i].mn), int'(vecs[i].sc), int'(vecs[i].b));
        end

        // Asynchronous reset in the middle of an adjustment
        do_reset();
        pulse(1, 0, 0, 0);
        repeat (5) pulse(0, 1, 0, 0);
        pulse(1, 0, 0, 0);
        repeat (30) pulse(0, 1, 0, 0);
        chk_all("pre_rst", 2, 5, 30, 0, 1);
        #2 RST = 1'b1;
        #1 chk_all("rst_async", 0, 0, 0, 0, 0);
        @(posedge CLK);
        #1 chk_all("rst_held", 0, 0, 0, 0, 0);
        RST = 1'b0;
        pulse(0, 0, 0, 0);
        chk_all("rst_release", 0, 0, 0, 0, 0);

        // Hour wrap and 61 minute increments without carry
        do_reset();
        pulse(1, 0, 0, 0);
        repeat (22) pulse(0, 1, 0, 0);
        chk("hour22", int'(HOUR), 22);
        pulse(0, 1, 0, 0); chk("hour_23", int'(HOUR), 23);
        pulse(0, 1, 0, 0); chk("hour_wrap0", int'(HOUR), 0);
        pulse(0, 1, 0, 0); chk("hour_1", int'(HOUR), 1);
        pulse(1, 0, 0, 0); chk("to_set_min", int'(STATE), 2);
        repeat (61) pulse(0, 1, 0, 0);
        chk("min61.MIN", int'(MIN), 1);
        chk("min61.HOUR", int'(HOUR), 1);
        pulse(1, 0, 0, 0);
        chk_all("set_exit", 0, 1, 1, 0, 0);

        // Full rollover 23:59:59 -> 00:00:00 in one edge
        do_reset();
        pulse(1, 0, 0, 0);
        repeat (23) pulse(0, 1, 0, 0);
        pulse(1, 0, 0, 0);
        repeat (59) pulse(0, 1, 0, 0);
        pulse(1, 0, 0, 0);
        repeat (58) pulse(0, 0, 1, 0);
        chk_all("preload", 0, 23, 59, 58, 0);
        pulse(0, 0, 1, 0);
        chk_all("t235959", 0, 23, 59, 59, 0);
        pulse(0, 0, 1, 0);
        chk_all("rollover", 0, 0, 0, 0, 0);

        // MODE together with a carrying tick
        do_reset();
        repeat (59) pulse(0, 0, 1, 0);
        chk("sec59", int'(SEC), 59);
        pulse(1, 0, 1, 0);
        chk_all("mode_tick_carry", 1, 0, 1, 0, 1);

        // Illegal state encoding recovers to RUN
        pulse(1, 0, 0, 0);
        pulse(1, 0, 0, 0);
        repeat (2) pulse(0, 0, 1, 0);
        chk_all("pre_force", 0, 0, 1, 2, 0);
        force dut.state_q = 2'b11;
        #1 chk("forced_state", int'(STATE), 3);
        #5 release dut.state_q;
        @(posedge CLK);
        #1 chk_all("illegal_recover", 0, 0, 1, 2, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
